// File: rtl/piano_pkg.sv
// piano_pkg: note/octave encodings shared by the key encoder and the tone generator.
package piano_pkg;

    localparam int NOTE_W   = 3;
    localparam int OCT_W    = 3;
    localparam int NUM_KEYS = 7;
    localparam logic [OCT_W-1:0] OCT_MAX = 3'd7;

    typedef enum logic [NOTE_W-1:0] {
        NOTE_NONE = 3'd0,
        NOTE_C    = 3'd1,
        NOTE_D    = 3'd2,
        NOTE_E    = 3'd3,
        NOTE_F    = 3'd4,
        NOTE_G    = 3'd5,
        NOTE_A    = 3'd6,
        NOTE_B    = 3'd7
    } note_e;

    // Lowest-index set key wins; no key maps to silence.
    function automatic note_e lowest_note(input logic [NUM_KEYS-1:0] keys);
        lowest_note = NOTE_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (keys[i]) lowest_note = note_e'(NOTE_W'(i + 1));
    endfunction

    function automatic logic [NUM_KEYS-1:0] note_mask(input note_e n);
        note_mask = (n == NOTE_NONE) ? '0 : NUM_KEYS'(1) << (NOTE_W'(n) - NOTE_W'(1));
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser followed by a consecutive-cycle debounce counter
// producing a stable level and single-cycle rise/fall pulses.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_100M,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          rise_q, fall_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;

    always_comb begin
        flip     = (sync2_q != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d    = (sync2_q == stable_q || flip) ? '0 : cnt_q + 1'b1;
        stable_d = stable_q ^ flip;
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= flip & ~stable_q;
            fall_q   <= flip & stable_q;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/key_note_encoder.sv
// key_note_encoder: debounces piano keys and octave buttons, tracks the sounding note
// (last press wins) and a saturating octave for the tone generator.
module key_note_encoder
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int OCTAVE_RESET    = 3
) (
    input  logic                clk_100M,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic                oct_up_in,
    input  logic                oct_down_in,
    output logic [NOTE_W-1:0]   note,
    output logic [OCT_W-1:0]    octave,
    output logic                key_active
);

    logic [NUM_KEYS-1:0] key_stable, key_rise, key_fall;
    logic                up_rise, dn_rise;
    logic [3:0]          oct_unused;
    note_e               note_q, note_d;
    logic [OCT_W-1:0]    octave_q, octave_d;
    logic                key_active_q, key_active_d;
    logic                up_only, dn_only, sounding_fell;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_100M (clk_100M),
            .rst      (rst),
            .raw      (key_in[g]),
            .stable   (key_stable[g]),
            .rise     (key_rise[g]),
            .fall     (key_fall[g])
        );
    end

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk_100M (clk_100M),
        .rst      (rst),
        .raw      (oct_up_in),
        .stable   (oct_unused[0]),
        .rise     (up_rise),
        .fall     (oct_unused[1])
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk_100M (clk_100M),
        .rst      (rst),
        .raw      (oct_down_in),
        .stable   (oct_unused[2]),
        .rise     (dn_rise),
        .fall     (oct_unused[3])
    );

    // key_stable already reflects this cycle's rise/fall, so a fall re-selects among keys still held.
    always_comb begin
        sounding_fell = |(key_fall & note_mask(note_q));
        note_d        = (|key_rise) ? lowest_note(key_rise) :
                        sounding_fell ? lowest_note(key_stable) : note_q;
        key_active_d  = |key_stable;
        up_only       = up_rise & ~dn_rise;
        dn_only       = dn_rise & ~up_rise;
        octave_d      = (up_only && octave_q != OCT_MAX) ? octave_q + 1'b1 :
                        (dn_only && octave_q != '0)      ? octave_q - 1'b1 : octave_q;
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            note_q       <= NOTE_NONE;
            octave_q     <= OCT_W'(OCTAVE_RESET);
            key_active_q <= 1'b0;
        end else begin
            note_q       <= note_d;
            octave_q     <= octave_d;
            key_active_q <= key_active_d;
        end
    end

    assign note       = note_q;
    assign octave     = octave_q;
    assign key_active = key_active_q;

endmodule

// File: tb/tb_key_note_encoder.sv
// tb_key_note_encoder: scoreboard bench; each stimulus step queues the expected outputs
// one edge before and exactly at the debounce latency, a negedge monitor compares them.
module tb_key_note_encoder;

    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    logic       clk_100M = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] key_in = '0;
    logic       oct_up_in = 1'b0;
    logic       oct_down_in = 1'b0;
    logic [2:0] note, octave;
    logic       key_active;

    key_note_encoder #(.DEBOUNCE_CYCLES(DEB), .OCTAVE_RESET(3)) dut (
        .clk_100M    (clk_100M),
        .rst         (rst),
        .key_in      (key_in),
        .oct_up_in   (oct_up_in),
        .oct_down_in (oct_down_in),
        .note        (note),
        .octave      (octave),
        .key_active  (key_active)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        int         due;
        logic [2:0] n;
        logic [2:0] o;
        logic       a;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [2:0] cur_n = 3'd0;
    logic [2:0] cur_o = 3'd3;
    logic       cur_a = 1'b0;

    always @(posedge clk_100M) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk_100M) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".note"},   8'(note),       8'(e.n));
            check({e.tag, ".octave"}, 8'(octave),     8'(e.o));
            check({e.tag, ".active"}, 8'(key_active), 8'(e.a));
        end
    end

    // Drive a new input level; outputs must be unchanged LAT-1 edges later and updated at LAT.
    task automatic step(input string tag, input logic [6:0] k, input logic u, input logic d,
                        input logic [2:0] n, input logic [2:0] o, input logic a, input int hold);
        key_in      = k;
        oct_up_in   = u;
        oct_down_in = d;
        rst         = 1'b0;
        sb.push_back('{cyc + LAT - 1, cur_n, cur_o, cur_a, {tag, "-pre"}});
        cur_n = n;
        cur_o = o;
        cur_a = a;
        sb.push_back('{cyc + LAT, cur_n, cur_o, cur_a, tag});
        repeat (hold) @(posedge clk_100M);
        #1;
    endtask

    logic [2:0] up_seq [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7};

    initial begin
        rst    = 1'b1;
        key_in = 7'b0000100;
        repeat (2) begin
            @(posedge clk_100M);
            #1;
            check("rst.note",   8'(note),       8'd0);
            check("rst.octave", 8'(octave),     8'd3);
            check("rst.active", 8'(key_active), 8'd0);
        end
        step("rst_release", 7'b0000100, 0, 0, 3'd3, 3'd3, 1'b1, 12);
        step("rel_e",       7'b0000000, 0, 0, 3'd0, 3'd3, 1'b0, 12);
        step("glitch_hi",   7'b0000001, 0, 0, 3'd0, 3'd3, 1'b0, 3);
        step("glitch_lo",   7'b0000000, 0, 0, 3'd0, 3'd3, 1'b0, 12);
        step("hold4_c",     7'b0000001, 0, 0, 3'd1, 3'd3, 1'b1, 4);
        step("hold4_rel",   7'b0000000, 0, 0, 3'd0, 3'd3, 1'b0, 12);
        step("prio_c",      7'b0000001, 0, 0, 3'd1, 3'd3, 1'b1, 12);
        step("prio_g",      7'b0010001, 0, 0, 3'd5, 3'd3, 1'b1, 12);
        step("prio_rel_g",  7'b0000001, 0, 0, 3'd1, 3'd3, 1'b1, 12);
        step("prio_rel_c",  7'b0000000, 0, 0, 3'd0, 3'd3, 1'b0, 12);
        step("simul_e_a",   7'b0100100, 0, 0, 3'd3, 3'd3, 1'b1, 12);
        step("rel_a_quiet", 7'b0000100, 0, 0, 3'd3, 3'd3, 1'b1, 12);
        step("rel_all",     7'b0000000, 0, 0, 3'd0, 3'd3, 1'b0, 12);
        step("hold_c",      7'b0000001, 0, 0, 3'd1, 3'd3, 1'b1, 12);
        for (int i = 0; i < 5; i++) begin
            step("oct_up",     7'b0000001, 1, 0, 3'd1, up_seq[i], 1'b1, 12);
            step("oct_up_rel", 7'b0000001, 0, 0, 3'd1, cur_o,     1'b1, 12);
        end
        for (int i = 0; i < 9; i++) begin
            step("oct_dn",     7'b0000001, 0, 1, 3'd1, (cur_o == 3'd0) ? 3'd0 : cur_o - 3'd1, 1'b1, 12);
            step("oct_dn_rel", 7'b0000001, 0, 0, 3'd1, cur_o, 1'b1, 12);
        end
        for (int i = 0; i < 3; i++) begin
            step("oct_restore",     7'b0000000, 1, 0, 3'd0, cur_o + 3'd1, 1'b0, 12);
            step("oct_restore_rel", 7'b0000000, 0, 0, 3'd0, cur_o,        1'b0, 12);
        end
        step("oct_both",      7'b0000000, 1, 1, 3'd0, 3'd3, 1'b0, 12);
        step("oct_both_rel",  7'b0000000, 0, 0, 3'd0, 3'd3, 1'b0, 12);
        step("oct_hold",      7'b0000000, 1, 0, 3'd0, 3'd4, 1'b0, 100);
        step("oct_hold_rel",  7'b0000000, 0, 0, 3'd0, 3'd4, 1'b0, 12);
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk_100M);
        #1;
        check("drain", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_note_encoder.md
Name: key_note_encoder

Overview:
- Front-end stage that feeds the tone generator: converts raw piano-key and octave push-buttons into the registered `note`/`octave` pair the tone generator consumes.
- Synchronises and debounces every button.
- Tracks the sounding note with last-pressed-wins priority.
- Holds a saturating octave register.
- Drives `note` = 0 (silence code) when no key is held.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from its stable value before the stable value flips (10 ms at 100 MHz); legal range >= 2.
- OCTAVE_RESET, 3, octave value loaded on reset; legal range 0..7.

Ports:
- clk_100M  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- key_in  input  7  raw key buttons, active-high, asynchronous to the clock; bit k = note code k+1 (bit0 = C … bit6 = B).
- oct_up_in  input  1  raw octave-up button, active-high, asynchronous.
- oct_down_in  input  1  raw octave-down button, active-high, asynchronous.
- note  output  3  sounding note code, 0 = none, 1..7 = C..B; registered.
- octave  output  3  current octave 0..7; registered.
- key_active  output  1  1 when any debounced key is held; registered.

Behaviour:
- Clock and reset: one clock, `clk_100M`; reset `rst` is synchronous and active-high.
- Reset values (all registered state):
  - `note` = 0, `key_active` = 0, `octave` = OCTAVE_RESET.
  - All synchroniser flops 0; all stable states 0 (released); all debounce counters 0.
- Reset mid-operation returns everything to these values the next edge. A key still held after reset is then treated as a fresh press once debounced.
- Synchroniser: each of the 9 inputs passes through 2 flops before use.
- Debounce, per input:
  - `cnt` clears whenever `sync == stable`; otherwise it increments.
  - When `sync != stable` and `cnt == DEBOUNCE_CYCLES-1`, `stable` flips on that edge, `cnt` clears, and a 1-cycle `rise` or `fall` pulse is registered on the same edge.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `stable`.
  - `cnt` width is clog2(DEBOUNCE_CYCLES); no wrap is possible.
- Latency: a clean raw level change reaches `note`/`octave`/`key_active` exactly DEBOUNCE_CYCLES+3 edges after the first edge that samples it (2 synchroniser + DEBOUNCE_CYCLES debounce + 1 output).
- Note tracking, evaluated each cycle from the debounce pulses:
  - Any key `rise` → `note` = (lowest-index rising key)+1. Simultaneous rises: the lowest index wins.
  - Else, `fall` of the key whose code equals `note` → `note` = (lowest-index key still stably held)+1, or 0 if none.
  - Else, `fall` of a key not currently sounding → `note` unchanged.
  - A rise and a fall in the same cycle: the rise rule applies.
  - `key_active` = OR of the next-state stable key vector, registered.
- Octave:
  - `oct_up` rise → `octave`+1, saturating at 7.
  - `oct_down` rise → `octave`-1, saturating at 0.
  - Both rising in the same cycle → no change.
  - Holding a button produces no auto-repeat.
- Octave changes do not alter `note`.

Decomposition:
- Shared package `piano_pkg`:
  - note code constants NOTE_NONE=0, NOTE_C=1 … NOTE_B=7.
  - NOTE_W=3, OCT_W=3, OCT_MAX=7.
  - tone generator uses the same constants.
- Sub-module `button_debouncer`: one 2-flop synchroniser plus debounce counter.
  - Ports: clk_100M, rst, raw, stable, rise, fall.
  - Parameter DEBOUNCE_CYCLES.
  - Instantiated 9 times.
- Top level holds the note priority logic and the octave register.

Test Plan (bench uses DEBOUNCE_CYCLES=4, OCTAVE_RESET=3):
- Reset check: assert `rst` for 2 cycles with `key_in`=7'b0000100 held → during/after reset `note`=0, `octave`=3, `key_active`=0; after release, `note`=3 and `key_active`=1 exactly 7 edges after the first post-reset edge.
- Glitch rejection: pulse `key_in[0]` high for 3 cycles, then low → `note` stays 0. A 4-cycle hold followed by release → `note`=1 appears after 7 edges, then returns to 0 after release + 7 edges.
- Last-press priority: hold C (bit0), later press G (bit4) → `note` 1→5. Release G → `note`=1. Release C → `note`=0, `key_active`=0.
- Simultaneous press: raise bits 2 and 5 on the same cycle → `note`=3. Then release bit 5 (not sounding) → `note` stays 3.
- Octave saturation: from 3, five debounced `oct_up` presses → `octave` 4,5,6,7,7. Eight `oct_down` presses → ends at 0 and stays 0 on a further press.
- Simultaneous octave buttons: `oct_up` and `oct_down` rising on the same cycle with `octave`=3 → `octave` stays 3. Holding `oct_up` for 100 cycles → exactly one increment.
